array_41_port_ctrl: RTL

Request front-end that drives the 512x48 single-port masked SRAM macro (array_41_ext RW0 port) and consumes its 1-cycle-latency read data. It converts a valid/ready request stream into SRAM enable, write-mode, mask and data controls. Read data is buffered in a small response FIFO with backpressure, so the macro's unheld output is never lost. An optional post-reset sweep writes every entry to a known value.

---
 rtl/array_41_port_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/array_41_port_ctrl.sv
// Valid/ready request front-end for the array_41_ext 512x48 masked SRAM (RW0 port).
// Optional build macro ARRAY41_CTRL_INIT_EN adds a post-reset sweep writing INIT_VALUE everywhere.
module array_41_port_ctrl #(
  parameter int                DEPTH      = 512,
  parameter int                ADDR_W     = 9,
  parameter int                DATA_W     = 48,
  parameter int                MASK_SEG   = 8,
  parameter int                RESP_DEPTH = 2,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [MASK_SEG-1:0] req_wmask,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                mem_en,
  output logic                mem_wmode,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [MASK_SEG-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                init_done
);

  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W  = $clog2(RESP_DEPTH);
  localparam int USED_W = CNT_W + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic                accept_p0;
  logic                rd_issue_p0;
  logic                pop;
  logic                credit_ok;
  logic [USED_W-1:0]   used;
  logic                rd_vld_p1;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   fifo_mem [RESP_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef ARRAY41_CTRL_INIT_EN
  localparam state_t RST_STATE = INIT;

  logic [ADDR_W-1:0] sweep_cnt;
  logic              sweep_last;

  assign sweep_last = (sweep_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      sweep_cnt <= '0;
    else if (state == INIT && !sweep_last)
      sweep_cnt <= sweep_cnt + 1'b1;
  end
`else
  localparam state_t RST_STATE = RUN;

  logic unused_init_cfg;
  assign unused_init_cfg = ^{INIT_VALUE, DEPTH};
`endif

  always_comb begin
    state_nxt = state;
`ifdef ARRAY41_CTRL_INIT_EN
    if (state == INIT && sweep_last)
      state_nxt = RUN;
`endif
  end

  // A pop this cycle frees a slot, which is what lets reads stream at one per cycle.
  assign resp_valid  = (fifo_cnt != '0);
  assign pop         = resp_valid & resp_ready;
  assign used        = USED_W'(fifo_cnt) + USED_W'(rd_vld_p1) - USED_W'(pop);
  assign credit_ok   = (used < USED_W'(RESP_DEPTH));
  assign req_ready   = ~reset & (state == RUN) & (req_write | credit_ok);
  assign accept_p0   = req_valid & req_ready;
  assign rd_issue_p0 = accept_p0 & ~req_write;
  assign init_done   = (state == RUN);
  assign resp_data   = fifo_mem[rd_ptr];

  // ---- p0: request drives the SRAM port directly ----
  always_comb begin
    mem_en    = accept_p0;
    mem_wmode = req_write;
    mem_addr  = req_addr;
    mem_wmask = req_wmask;
    mem_wdata = req_wdata;
`ifdef ARRAY41_CTRL_INIT_EN
    if (state == INIT) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = sweep_cnt;
      mem_wmask = '1;
      mem_wdata = INIT_VALUE;
    end
`endif
    if (reset) begin
      mem_en    = 1'b0;
      mem_wmode = 1'b0;
      mem_addr  = '0;
      mem_wmask = '0;
      mem_wdata = '0;
    end
  end

  // ---- p1: SRAM read data arrives and is captured into the response FIFO ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RST_STATE;
      rd_vld_p1 <= 1'b0;
      fifo_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= rd_issue_p0;
      fifo_cnt  <= fifo_cnt + CNT_W'(rd_vld_p1) - CNT_W'(pop);
      if (rd_vld_p1)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clock) begin
    if (rd_vld_p1)
      fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule
